// File: rtl/rf_pkg.sv
// Shared widths, writeback request type and grant encoding for the
// register-file writeback scheduler.
package rf_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDRESS_WIDTH = 5;
  localparam int unsigned NUM_REGS      = 32;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-granted pointer only moves when
// both requesters compete, so an uncontested grant leaves priority as is.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic [1:0] gnt
);

  grant_e rr_last_q, rr_last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= GNT_B;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    gnt       = '0;
    rr_last_d = rr_last_q;
    if (req_a && req_b) begin
      if (rr_last_q == GNT_B) begin
        gnt[GNT_A] = 1'b1;
        rr_last_d  = GNT_A;
      end else begin
        gnt[GNT_B] = 1'b1;
        rr_last_d  = GNT_B;
      end
    end else begin
      gnt[GNT_A] = req_a;
      gnt[GNT_B] = req_b;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single RegFile write port between the ALU and load pipes
// and tracks pending destination writes to stall issue on RAW/WAW hazards.
module rf_wb_scheduler #(
  parameter int unsigned DATA_WIDTH    = rf_pkg::DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int unsigned NUM_REGS      = rf_pkg::NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic                     iss_wr,
  input  logic [ADDRESS_WIDTH-1:0] iss_dest,
  input  logic [ADDRESS_WIDTH-1:0] iss_rs1,
  input  logic [ADDRESS_WIDTH-1:0] iss_rs2,
  output logic                     iss_stall,
  input  logic                     a_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_dest,
  input  logic [DATA_WIDTH-1:0]    a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDRESS_WIDTH-1:0] b_dest,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     b_ready,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data
);
  import rf_pkg::*;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]    data;
  } wb_sel_t;

  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [NUM_REGS-1:0]      set_mask, clr_mask;
  logic [1:0]               gnt;
  wb_sel_t                  sel;
  logic                     iss_accept;
  logic                     wb_launch;
  logic                     rg_wrt_en_q, rg_wrt_en_d;
  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest_q, rg_wrt_dest_d;
  logic [DATA_WIDTH-1:0]    rg_wrt_data_q, rg_wrt_data_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt   (gnt)
  );

  assign a_ready = gnt[GNT_A];
  assign b_ready = gnt[GNT_B];

  always_comb begin
    iss_stall  = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] |
                              (iss_wr & busy_q[iss_dest]));
    iss_accept = iss_valid & ~iss_stall & iss_wr & (iss_dest != '0);
    set_mask   = '0;
    if (iss_accept) begin
      set_mask[iss_dest] = 1'b1;
    end
  end

  // Any valid requester is always granted, so a handshake happens whenever
  // either side is valid; dest 0 is accepted but never reaches the RegFile.
  always_comb begin
    sel.dest      = a_dest;
    sel.data      = a_data;
    if (gnt[GNT_B]) begin
      sel.dest = b_dest;
      sel.data = b_data;
    end
    wb_launch     = (a_valid | b_valid) & (sel.dest != '0);
    clr_mask      = '0;
    if (wb_launch) begin
      clr_mask[sel.dest] = 1'b1;
    end
    // Set is applied after clear so a same-cycle issue to the register wins.
    busy_d        = (busy_q & ~clr_mask) | set_mask;
    busy_d[0]     = 1'b0;
    rg_wrt_en_d   = wb_launch;
    rg_wrt_dest_d = rg_wrt_dest_q;
    rg_wrt_data_d = rg_wrt_data_q;
    if (wb_launch) begin
      rg_wrt_dest_d = sel.dest;
      rg_wrt_data_d = sel.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      rg_wrt_en_q   <= 1'b0;
      rg_wrt_dest_q <= '0;
      rg_wrt_data_q <= '0;
    end else begin
      busy_q        <= busy_d;
      rg_wrt_en_q   <= rg_wrt_en_d;
      rg_wrt_dest_q <= rg_wrt_dest_d;
      rg_wrt_data_q <= rg_wrt_data_d;
    end
  end

  assign rg_wrt_en   = rg_wrt_en_q;
  assign rg_wrt_dest = rg_wrt_dest_q;
  assign rg_wrt_data = rg_wrt_data_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scenario bench for rf_wb_scheduler: accepted writebacks are queued as
// expected RegFile writes and matched against rg_wrt_* on each negedge.
module tb_rf_wb_scheduler;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0, iss_wr = 1'b0;
  logic [4:0]  iss_dest = '0, iss_rs1 = '0, iss_rs2 = '0;
  logic        iss_stall;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_dest = '0, b_dest = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rf_wb_scheduler #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_REGS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_wr      (iss_wr),
    .iss_dest    (iss_dest),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_stall   (iss_stall),
    .a_valid     (a_valid),
    .a_dest      (a_dest),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_dest      (b_dest),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_dest (rg_wrt_dest),
    .rg_wrt_data (rg_wrt_data)
  );

  // Every launched RegFile write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rg_wrt_en) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got write x%0d=%h, expected none", rg_wrt_dest, rg_wrt_data);
      end else begin
        e = exp_q.pop_front();
        if (rg_wrt_dest !== e.dest || rg_wrt_data !== e.data) begin
          n_fail++;
          $display("FAIL wb_data: got x%0d=%h, expected x%0d=%h", rg_wrt_dest, rg_wrt_data, e.dest, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_wr = 1'b0; iss_dest = '0; iss_rs1 = '0; iss_rs2 = '0;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
    iss_valid = 1'b1; iss_wr = wr; iss_dest = d; iss_rs1 = r1; iss_rs2 = r2;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    #1;
    n_checks++;
    if (iss_stall !== exp) begin
      n_fail++;
      $display("FAIL %s: iss_stall=%b expected %b", name, iss_stall, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    #12;
    n_checks++;
    if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 5'd0 || rg_wrt_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b dest=%0d data=%h expected 0/0/0", rg_wrt_en, rg_wrt_dest, rg_wrt_data);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    issue(1'b0, 5'd0, 5'd3, 5'd4);
    chk_stall("reset_no_busy", 1'b0);
    n_checks++;
    if (rg_wrt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wrt_en: rg_wrt_en=%b expected 0", rg_wrt_en);
    end
    idle();
  endtask

  task automatic test_raw();
    issue(1'b1, 5'd5, 5'd1, 5'd2);
    chk_stall("raw_issue_dest5", 1'b0);
    step();
    issue(1'b0, 5'd0, 5'd5, 5'd0);
    chk_stall("raw_stall_rs1_5", 1'b1);
    a_valid = 1'b1; a_dest = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_a_ready: a_ready=%b expected 1", a_ready);
    end
    exp_q.push_back('{5'd5, 32'hDEADBEEF});
    step();
    a_valid = 1'b0;
    n_checks++;
    if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd5 || rg_wrt_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL raw_launch: en=%b x%0d=%h expected 1 x5=deadbeef", rg_wrt_en, rg_wrt_dest, rg_wrt_data);
    end
    chk_stall("raw_stall_cleared", 1'b0);
    idle();
    step();
    n_checks++;
    if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 5'd5) begin
      n_fail++;
      $display("FAIL raw_hold: en=%b dest=%0d expected 0 with dest held at 5", rg_wrt_en, rg_wrt_dest);
    end
  endtask

  task automatic test_arbitration();
    a_valid = 1'b1; a_dest = 5'd6; a_data = 32'h11;
    b_valid = 1'b1; b_dest = 5'd7; b_data = 32'h22;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_cycle1: a_ready=%b b_ready=%b expected 1/0", a_ready, b_ready);
    end
    exp_q.push_back('{5'd6, 32'h11});
    step();
    #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_cycle2: a_ready=%b b_ready=%b expected 0/1", a_ready, b_ready);
    end
    exp_q.push_back('{5'd7, 32'h22});
    step();
    a_dest = 5'd12; a_data = 32'h33; b_dest = 5'd13; b_data = 32'h44;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_cycle3: a_ready=%b b_ready=%b expected 1/0", a_ready, b_ready);
    end
    exp_q.push_back('{5'd12, 32'h33});
    step();
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_b_alone: b_ready=%b expected 1", b_ready);
    end
    exp_q.push_back('{5'd13, 32'h44});
    step();
    idle();
    step();
  endtask

  task automatic test_dest0();
    issue(1'b1, 5'd0, 5'd1, 5'd2);
    step();
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    chk_stall("dest0_never_busy", 1'b0);
    iss_valid = 1'b0;
    a_valid = 1'b1; a_dest = 5'd0; a_data = 32'h55;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dest0_ready: a_ready=%b expected 1", a_ready);
    end
    step();
    a_valid = 1'b0;
    n_checks++;
    if (rg_wrt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL dest0_no_write: rg_wrt_en=%b expected 0", rg_wrt_en);
    end
    idle();
  endtask

  task automatic test_waw();
    issue(1'b1, 5'd8, 5'd1, 5'd2);
    step();
    issue(1'b1, 5'd8, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      chk_stall("waw_hold", 1'b1);
      step();
    end
    a_valid = 1'b1; a_dest = 5'd8; a_data = 32'h88;
    exp_q.push_back('{5'd8, 32'h88});
    chk_stall("waw_hold_at_wb", 1'b1);
    step();
    a_valid = 1'b0;
    chk_stall("waw_released", 1'b0);
    idle();
    step();
  endtask

  task automatic test_set_clear_same_cycle();
    issue(1'b1, 5'd10, 5'd1, 5'd2);
    a_valid = 1'b1; a_dest = 5'd10; a_data = 32'hA0;
    exp_q.push_back('{5'd10, 32'hA0});
    chk_stall("setclr_no_stall", 1'b0);
    step();
    a_valid = 1'b0;
    issue(1'b0, 5'd0, 5'd10, 5'd0);
    chk_stall("setclr_set_wins", 1'b1);
    iss_valid = 1'b0;
    a_valid = 1'b1; a_data = 32'hA1;
    exp_q.push_back('{5'd10, 32'hA1});
    step();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_dest  = 5'(16 + i);
      a_data  = 32'h1000 + 32'(i);
      exp_q.push_back('{a_dest, a_data});
      step();
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 5'd9, 5'd1, 5'd2);
    step();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_dest = 5'd11; a_data = 32'hBAD;
    step();
    a_valid = 1'b0;
    n_checks++;
    if (rg_wrt_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_inflight: rg_wrt_en=%b expected 1", rg_wrt_en);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rg_wrt_en !== 1'b0 || rg_wrt_data !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: en=%b data=%h expected 0/0", rg_wrt_en, rg_wrt_data);
    end
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    issue(1'b0, 5'd0, 5'd9, 5'd0);
    chk_stall("rstmid_busy_dropped", 1'b0);
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_arbitration();
    test_dest0();
    test_waw();
    test_set_clear_same_cycle();
    test_back_to_back();
    test_reset_mid();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wb_missing: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
